spi_mic_reader: RTL and testbench

- SPI master that reads the external SPI microphone board (12-bit ADC, 16-bit frames, MSB first) on SPI_SS/SPI_CLK/SPI_MISO.
- Produces a fixed-rate PCM sample stream and writes it into the delay-buffer BRAM through the same port-A write interface as the PDM input path: address, enable, data.
- Provides the receive end of the SPI_* ports on the top level, as a selectable alternative to the on-board PDM microphone.

---
 rtl/spi_mic_reader_pkg.sv | 29 ++
 rtl/spi_mic_reader_sclk_gen.sv | 51 +++++
 rtl/spi_mic_reader.sv | 141 ++++++++++++++
 tb/tb_spi_mic_reader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mic_reader_pkg.sv
// Shared types and constants for the SPI microphone path (package audio_pkg).
// Define MIC_SIGNED_EN to emit left-justified two's-complement samples instead of zero-extended.
package audio_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StQuiet,
        StWrite
    } mic_state_e;

    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned ADC_BITS   = 12;
    localparam int unsigned LEAD_ZEROS = 4;
    localparam int unsigned FRAME_BITS = 16;

    // The leading-zero nibble of the frame carries no data and is dropped here.
    function automatic logic [SAMPLE_W-1:0] format_sample(input logic [FRAME_BITS-1:0] frame);
        logic [ADC_BITS-1:0] d;
        d = frame[ADC_BITS-1:0];
`ifdef MIC_SIGNED_EN
        return {~d[ADC_BITS-1], d[ADC_BITS-2:0], {LEAD_ZEROS{1'b0}}};
`else
        return {{LEAD_ZEROS{1'b0}}, d};
`endif
    endfunction

endpackage

// File: rtl/spi_mic_reader_sclk_gen.sv
// SCLK half-period divider: idles high, starts on a low phase, stops after a high phase.
// Emits a phase-end strobe and a capture strobe on the last cycle of each high phase.
module spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic stop,
    output logic sclk,
    output logic phase_end,
    output logic capture
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DivLast = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_q;
    logic          level_q;
    logic          active_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            level_q  <= 1'b1;
            active_q <= 1'b0;
        end else if (start) begin
            div_q    <= '0;
            level_q  <= 1'b0;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (div_q == DivLast) begin
                div_q <= '0;
                // Stopping only ever lands on a high phase end, so SCLK stays high.
                if (stop) begin
                    level_q  <= 1'b1;
                    active_q <= 1'b0;
                end else begin
                    level_q <= ~level_q;
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign sclk      = level_q;
    assign phase_end = active_q && (div_q == DivLast);
    assign capture   = phase_end && level_q;

endmodule

// File: rtl/spi_mic_reader.sv
// SPI master reading a 12-bit ADC at a fixed sample rate and writing samples to the delay BRAM.
// Sample format is selected by MIC_SIGNED_EN (see audio_pkg::format_sample).
module spi_mic_reader
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 5,
    parameter int unsigned SAMPLE_PERIOD = 2083,
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned BUF_DEPTH     = 65536
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  SPI_MISO,
    output logic                  SPI_SS,
    output logic                  SPI_CLK,
    output logic [ADDR_WIDTH-1:0] write_address,
    output logic                  write_enable,
    output logic [SAMPLE_W-1:0]   write_data,
    output logic                  sample_valid,
    output logic                  overrun
);

    localparam int unsigned RW = $clog2(SAMPLE_PERIOD);
    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [RW-1:0]         RateLast = RW'(SAMPLE_PERIOD - 1);
    localparam logic [CW-1:0]         DivLast  = CW'(CLK_DIV - 1);
    localparam logic [ADDR_WIDTH-1:0] AddrLast = ADDR_WIDTH'(BUF_DEPTH - 1);
    localparam logic [3:0]            LastBit  = 4'(FRAME_BITS - 1);

    mic_state_e state_q, state_d;

    logic [RW-1:0]         rate_q;
    logic [CW-1:0]         cnt_q;
    logic [3:0]            bit_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic                  miso_meta_q;
    logic                  miso_sync_q;
    logic                  ss_q;
    logic [SAMPLE_W-1:0]   data_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  overrun_q;

    logic tick;
    logic sclk_start;
    logic sclk_stop;
    logic sclk_level;
    logic phase_end;
    logic capture;

    assign tick = enable && (rate_q == RateLast);

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk      (clk),
        .reset    (reset),
        .start    (sclk_start),
        .stop     (sclk_stop),
        .sclk     (sclk_level),
        .phase_end(phase_end),
        .capture  (capture)
    );

    always_comb begin
        state_d    = state_q;
        sclk_start = 1'b0;
        sclk_stop  = 1'b0;
        case (state_q)
            StIdle:  if (tick) state_d = StSetup;
            StSetup: begin
                if (cnt_q == DivLast) begin
                    state_d    = StShift;
                    sclk_start = 1'b1;
                end
            end
            StShift: begin
                if (phase_end && sclk_level && (bit_q == LastBit)) begin
                    state_d   = StQuiet;
                    sclk_stop = 1'b1;
                end
            end
            StQuiet: if (cnt_q == DivLast) state_d = StWrite;
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            rate_q      <= '0;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
            ss_q        <= 1'b1;
            data_q      <= '0;
            addr_q      <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            miso_meta_q <= SPI_MISO;
            miso_sync_q <= miso_meta_q;

            if (!enable || (rate_q == RateLast)) rate_q <= '0;
            else                                 rate_q <= rate_q + 1'b1;

            if (tick && (state_q != StIdle)) overrun_q <= 1'b1;

            if ((state_d == state_q) && ((state_q == StSetup) || (state_q == StQuiet))) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end

            if ((state_q == StIdle) && tick) ss_q <= 1'b0;
            else if (sclk_stop)              ss_q <= 1'b1;

            // bit_q wraps to 0 after the 16th capture, ready for the next frame.
            if (capture) begin
                shift_q <= {shift_q[FRAME_BITS-2:0], miso_sync_q};
                bit_q   <= bit_q + 1'b1;
            end

            if ((state_q == StQuiet) && (state_d == StWrite)) data_q <= format_sample(shift_q);

            if (state_q == StWrite) addr_q <= (addr_q == AddrLast) ? '0 : addr_q + 1'b1;
        end
    end

    assign SPI_SS        = ss_q;
    assign SPI_CLK       = sclk_level;
    assign write_enable  = (state_q == StWrite);
    assign sample_valid  = write_enable;
    assign write_data    = data_q;
    assign write_address = addr_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_spi_mic_reader.sv
// Directed/randomized bench for spi_mic_reader with an SPI ADC slave model and write scoreboard.
// Instance A: slow enough rate for clean frames, BUF_DEPTH=4; instance B: rate faster than a frame.
module tb_spi_mic_reader;

    localparam int unsigned CLK_DIV = 5;
    localparam int unsigned SP_A    = 200;
    localparam int unsigned SP_B    = 100;
    localparam int unsigned DEPTH_A = 4;
    localparam int unsigned LAT     = 34 * CLK_DIV + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset_a = 1'b1, enable_a = 1'b0, miso_a = 1'b0;
    logic        ss_a, sclk_a, we_a, sv_a, ovr_a;
    logic [15:0] waddr_a, wdata_a;
    logic        reset_b = 1'b1, enable_b = 1'b0, miso_b = 1'b0;
    logic        ss_b, sclk_b, we_b, sv_b, ovr_b;
    logic [15:0] waddr_b, wdata_b;

    spi_mic_reader #(
        .CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP_A), .ADDR_WIDTH(16), .BUF_DEPTH(DEPTH_A)
    ) dut_a (
        .clk(clk), .reset(reset_a), .enable(enable_a), .SPI_MISO(miso_a), .SPI_SS(ss_a),
        .SPI_CLK(sclk_a), .write_address(waddr_a), .write_enable(we_a), .write_data(wdata_a),
        .sample_valid(sv_a), .overrun(ovr_a)
    );

    spi_mic_reader #(
        .CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP_B), .ADDR_WIDTH(16), .BUF_DEPTH(65536)
    ) dut_b (
        .clk(clk), .reset(reset_b), .enable(enable_b), .SPI_MISO(miso_b), .SPI_SS(ss_b),
        .SPI_CLK(sclk_b), .write_address(waddr_b), .write_enable(we_b), .write_data(wdata_b),
        .sample_valid(sv_b), .overrun(ovr_b)
    );

    // ADC slave models: a frame word is taken at SS fall, bits shifted out MSB first on SCLK fall.
    logic [15:0] adc_q_a[$], adc_q_b[$];
    logic [15:0] word_a = 16'h0, word_b = 16'h0;
    int          bit_a = -1, bit_b = -1;

    always @(negedge ss_a) begin
        if (adc_q_a.size() > 0) word_a = adc_q_a.pop_front();
        else                    word_a = 16'h0;
        bit_a = 15;
    end
    always @(negedge sclk_a) begin
        if (!ss_a && bit_a >= 0) begin
            miso_a = word_a[bit_a];
            bit_a--;
        end
    end
    always @(negedge ss_b) begin
        if (adc_q_b.size() > 0) word_b = adc_q_b.pop_front();
        else                    word_b = 16'h0;
        bit_b = 15;
    end
    always @(negedge sclk_b) begin
        if (!ss_b && bit_b >= 0) begin
            miso_b = word_b[bit_b];
            bit_b--;
        end
    end

    // Write log and bus monitors, sampled mid-cycle.
    typedef struct packed {
        logic [31:0] t;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         log_a[$], log_b[$];
    wr_t         mon_wa, mon_wb;
    int unsigned ss_fall_a_t = 0, falls_a = 0, rises_a = 0, ss_falls_a = 0, ss_falls_b = 0;
    int unsigned sv_bad = 0;
    logic        prev_sclk_a = 1'b1, prev_ss_a = 1'b1, prev_ss_b = 1'b1;

    always @(negedge clk) begin
        if (we_a) begin
            mon_wa.t = cyc; mon_wa.addr = waddr_a; mon_wa.data = wdata_a;
            log_a.push_back(mon_wa);
        end
        if (we_b) begin
            mon_wb.t = cyc; mon_wb.addr = waddr_b; mon_wb.data = wdata_b;
            log_b.push_back(mon_wb);
        end
        if ((sv_a !== we_a) || (sv_b !== we_b)) sv_bad++;
        if (prev_ss_a && !ss_a) begin
            ss_fall_a_t = cyc;
            falls_a     = 0;
            rises_a     = 0;
            ss_falls_a++;
        end
        if (!ss_a && prev_sclk_a && !sclk_a) falls_a++;
        if (!ss_a && !prev_sclk_a && sclk_a) rises_a++;
        if (prev_ss_b && !ss_b) ss_falls_b++;
        prev_ss_a   = ss_a;
        prev_sclk_a = sclk_a;
        prev_ss_b   = ss_b;
    end

    // Reference formatting: 12-bit offset-binary code, optionally re-centred and left-justified.
    function automatic logic [15:0] fmt(input logic [15:0] w);
        int code;
        code = int'(w) % 4096;
`ifdef MIC_SIGNED_EN
        code = (code - 2048) * 16;
        return 16'(code);
`else
        return 16'(code);
`endif
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        int unsigned p, n0, exp_addr, ss_low, we_cnt;
        wr_t         w;
        logic [15:0] words[6];
        logic [15:0] wb[3];

        repeat (3) @(negedge clk);
        check("rst_ss", ss_a, 1);
        check("rst_sclk", sclk_a, 1);
        check("rst_we", we_a, 0);
        check("rst_sv", sv_a, 0);
        check("rst_addr", waddr_a, 0);
        check("rst_data", wdata_a, 0);
        check("rst_ovr", ovr_a, 0);
        check("rst_ovr_b", ovr_b, 0);
        reset_a = 1'b0;
        reset_b = 1'b0;
        @(negedge clk);

        // Single frame, enable dropped during SETUP.
        adc_q_a.push_back(16'h0ABC);
        n0 = ss_falls_a;
        enable_a = 1'b1;
        p = cyc;
        for (int i = 0; i < int'(SP_A) + 10 && ss_falls_a == n0; i++) @(negedge clk);
        check("t1_ss_fell", ss_falls_a - n0, 1);
        check("t1_ss_time", ss_fall_a_t, p + SP_A);
        enable_a = 1'b0;
        for (int i = 0; i < int'(LAT) + 10 && log_a.size() == 0; i++) @(negedge clk);
        check("t1_nwrites", log_a.size(), 1);
        if (log_a.size() > 0) begin
            w = log_a.pop_front();
            check("t1_wtime", w.t, p + SP_A + LAT - 1);
            check("t1_waddr", w.addr, 0);
            check("t1_wdata", w.data, fmt(16'h0ABC));
        end
        check("t1_sclk_falls", falls_a, 16);
        check("t1_sclk_rises", rises_a, 16);
        check("t1_ss_high", ss_a, 1);
        @(negedge clk);
        check("t1_addr_inc", waddr_a, 1);
        exp_addr = 1;

        // Burst of six samples: format corners then random words, address wraps at 4.
        words[0] = 16'h0800;
        words[1] = 16'h0000;
        words[2] = 16'h0FFF;
        for (int k = 3; k < 6; k++) words[k] = 16'($urandom);
        for (int k = 0; k < 6; k++) adc_q_a.push_back(words[k]);
        n0 = ss_falls_a;
        enable_a = 1'b1;
        p = cyc;
        for (int i = 0; i < 7 * int'(SP_A) && ss_falls_a - n0 < 6; i++) @(negedge clk);
        enable_a = 1'b0;
        for (int i = 0; i < int'(LAT) + 10 && log_a.size() < 6; i++) @(negedge clk);
        check("t2_nwrites", log_a.size(), 6);
        for (int k = 0; k < 6 && log_a.size() > 0; k++) begin
            w = log_a.pop_front();
            check("t2_wtime", w.t, p + SP_A + LAT - 1 + k * SP_A);
            check("t2_waddr", w.addr, (exp_addr + k) % DEPTH_A);
            check("t2_wdata", w.data, fmt(words[k]));
        end
        exp_addr = (exp_addr + 6) % DEPTH_A;
        check("t2_ovr", ovr_a, 0);

        // Enable dropped during SHIFT: sample still lands, then the link stays quiet.
        words[0] = 16'($urandom);
        adc_q_a.push_back(words[0]);
        n0 = ss_falls_a;
        enable_a = 1'b1;
        p = cyc;
        for (int i = 0; i < int'(SP_A) + 10 && ss_falls_a == n0; i++) @(negedge clk);
        for (int i = 0; i < 100 && rises_a < 3; i++) @(negedge clk);
        check("t3_in_shift", (rises_a >= 3) && !ss_a, 1);
        enable_a = 1'b0;
        for (int i = 0; i < int'(LAT) + 10 && log_a.size() == 0; i++) @(negedge clk);
        check("t3_nwrites", log_a.size(), 1);
        if (log_a.size() > 0) begin
            w = log_a.pop_front();
            check("t3_wtime", w.t, p + SP_A + LAT - 1);
            check("t3_waddr", w.addr, exp_addr);
            check("t3_wdata", w.data, fmt(words[0]));
        end
        exp_addr = (exp_addr + 1) % DEPTH_A;
        ss_low = 0;
        we_cnt = 0;
        repeat (3 * SP_A) begin
            @(negedge clk);
            if (!ss_a) ss_low++;
            if (we_a) we_cnt++;
        end
        check("t3_quiet_ss", ss_low, 0);
        check("t3_quiet_we", we_cnt, 0);
        check("t3_addr_wrap", waddr_a, exp_addr);
        log_a.delete();

        // Reset at the 8th SCLK rising edge: frame aborted, nothing written.
        adc_q_a.push_back(16'h0123);
        n0 = ss_falls_a;
        enable_a = 1'b1;
        for (int i = 0; i < int'(SP_A) + 10 && ss_falls_a == n0; i++) @(negedge clk);
        for (int i = 0; i < 200 && rises_a < 8; i++) @(negedge clk);
        check("t4_rise8", rises_a, 8);
        reset_a = 1'b1;
        enable_a = 1'b0;
        @(negedge clk);
        check("t4_ss", ss_a, 1);
        check("t4_sclk", sclk_a, 1);
        check("t4_we", we_a, 0);
        check("t4_addr", waddr_a, 0);
        reset_a = 1'b0;
        repeat (2 * SP_A) @(negedge clk);
        check("t4_no_write", log_a.size(), 0);

        words[0] = 16'($urandom) & 16'h0FFF;
        adc_q_a.push_back(words[0]);
        n0 = ss_falls_a;
        enable_a = 1'b1;
        p = cyc;
        for (int i = 0; i < int'(SP_A) + 10 && ss_falls_a == n0; i++) @(negedge clk);
        enable_a = 1'b0;
        for (int i = 0; i < int'(LAT) + 10 && log_a.size() == 0; i++) @(negedge clk);
        check("t4_nwrites", log_a.size(), 1);
        if (log_a.size() > 0) begin
            w = log_a.pop_front();
            check("t4_wtime", w.t, p + SP_A + LAT - 1);
            check("t4_waddr", w.addr, 0);
            check("t4_wdata", w.data, fmt(words[0]));
        end

        // Instance B: period shorter than a frame, so every other tick is dropped.
        for (int k = 0; k < 3; k++) begin
            wb[k] = 16'($urandom) & 16'h0FFF;
            adc_q_b.push_back(wb[k]);
        end
        n0 = ss_falls_b;
        enable_b = 1'b1;
        p = cyc;
        while (cyc < p + 2 * SP_B - 1) @(negedge clk);
        check("t5_ovr_before", ovr_b, 0);
        @(negedge clk);
        check("t5_ovr_after", ovr_b, 1);
        for (int i = 0; i < 6 * int'(SP_B) && ss_falls_b - n0 < 3; i++) @(negedge clk);
        enable_b = 1'b0;
        for (int i = 0; i < int'(LAT) + 10 && log_b.size() < 3; i++) @(negedge clk);
        check("t5_nwrites", log_b.size(), 3);
        for (int k = 0; k < 3 && log_b.size() > 0; k++) begin
            w = log_b.pop_front();
            check("t5_wtime", w.t, p + SP_B - 1 + 2 * k * SP_B + LAT);
            check("t5_waddr", w.addr, k);
            check("t5_wdata", w.data, fmt(wb[k]));
        end
        check("t5_ovr_sticky", ovr_b, 1);
        reset_b = 1'b1;
        @(negedge clk);
        check("t5_ovr_cleared", ovr_b, 0);
        reset_b = 1'b0;
        @(negedge clk);

        check("sample_valid_copy", sv_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
